// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
//   Shared constants, FSM state type and the result record for the adder
//   tree frame controller and its pipelined tree core.
//   Optional build macro used by the tree core: ADDER_TREE_APPROX_EN.
package adder_tree_pkg;

    localparam int LANES    = 8;
    localparam int IN_W     = 8;
    localparam int SUM_W    = 11;
    localparam int CNT_W    = 4;
    localparam int TREE_LAT = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        LAUNCH  = 1'b1
    } state_e;

    // One FIFO entry: frame sum and the number of real samples in it.
    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
    } res_t;

endpackage

// File: rtl/adder_tree_core.sv
// adder_tree_core
//   8-input, 3-stage pipelined adder tree. Each stage registers one level of
//   pairwise node sums, so the result appears 3 edges after the lanes are
//   presented. Registers use the shared asynchronous active-high reset.
//   Build macro ADDER_TREE_APPROX_EN: when defined, each node adds the upper
//   bits exactly and XORs bits [2:0] (no carry out of the low 3 bits);
//   when undefined, each node is an exact full-width add.
// Ports:
//   clk, rst  - clock, async active-high reset
//   lanes_i   - 8 x 8-bit lane inputs
//   sum_o     - 11-bit registered tree output
module adder_tree_core
    import adder_tree_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0][IN_W-1:0] lanes_i,
    output logic [SUM_W-1:0]           sum_o
);

    // All levels are carried at the final width; inputs are zero-extended so
    // the upper bits of every level are simply unused zeros.
    function automatic logic [SUM_W-1:0] node(input logic [SUM_W-1:0] a,
                                              input logic [SUM_W-1:0] b);
`ifdef ADDER_TREE_APPROX_EN
        node = {a[SUM_W-1:3] + b[SUM_W-1:3], a[2:0] ^ b[2:0]};
`else
        node = a + b;
`endif
    endfunction

    logic [3:0][SUM_W-1:0] s1_d, s1_q;
    logic [1:0][SUM_W-1:0] s2_d, s2_q;
    logic [SUM_W-1:0]      s3_d, s3_q;

    always_comb begin
        s1_d = '0;
        s2_d = '0;
        for (int i = 0; i < 4; i++) begin
            s1_d[i] = node(SUM_W'(lanes_i[2*i]), SUM_W'(lanes_i[2*i+1]));
        end
        for (int i = 0; i < 2; i++) begin
            s2_d[i] = node(s1_q[2*i], s1_q[2*i+1]);
        end
        s3_d = node(s2_q[0], s2_q[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sum_o = s3_q;

endmodule

// File: rtl/adder_tree_frame_ctrl.sv
// adder_tree_frame_ctrl
//   Collects a serial 8-bit sample stream into 8-lane frames (short frames
//   closed by in_last are zero-padded), launches each frame into the 3-stage
//   adder tree, tracks in-flight frames with a valid shift register and
//   buffers results in a FIFO with a valid/ready output. Launch is
//   credit-gated so a tree result always finds room in the FIFO.
//   Build macro ADDER_TREE_APPROX_EN selects the approximate tree nodes;
//   the controller behaves identically in both builds.
// Ports:
//   clk, rst            - clock, async active-high reset
//   in_data/valid/last  - sample stream; in_last closes the frame early
//   in_ready            - high while collecting
//   out_sum/out_cnt     - FIFO head: frame sum and real sample count (1..8)
//   out_valid/out_ready - result handshake
module adder_tree_frame_ctrl
    import adder_tree_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    state_e                       state_d, state_q;
    logic [2:0]                   idx_d, idx_q;
    logic [CNT_W-1:0]             fcnt_d, fcnt_q;
    logic [LANES-1:0][IN_W-1:0]   lanes_d, lanes_q;
    logic [TREE_LAT-1:0]          v_d, v_q;
    logic [TREE_LAT-1:0][CNT_W-1:0] cp_d, cp_q;
    res_t [FIFO_DEPTH-1:0]        mem_d, mem_q;
    logic [PTR_W-1:0]             wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [OCC_W-1:0]             occ_d, occ_q;

    logic             accept, launch, credit_ok, push, pop;
    logic [SUM_W-1:0] tree_y;
    int               inflight;

    adder_tree_core u_tree (
        .clk     (clk),
        .rst     (rst),
        .lanes_i (lanes_q),
        .sum_o   (tree_y)
    );

    assign in_ready  = (state_q == COLLECT);
    assign accept    = in_valid & in_ready;
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = v_q[TREE_LAT-1];
    assign out_sum   = mem_q[rd_ptr_q].sum;
    assign out_cnt   = mem_q[rd_ptr_q].cnt;

    // Same-cycle pops are deliberately ignored: credit only frees up after
    // the pop has actually reduced occupancy.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < TREE_LAT; i++) begin
            inflight = inflight + int'(v_q[i]);
        end
        credit_ok = (int'(occ_q) + inflight) < FIFO_DEPTH;
    end

    // Frame collection FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        lanes_d = lanes_q;
        launch  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    lanes_d[idx_q] = in_data;
                    fcnt_d         = {1'b0, idx_q} + CNT_W'(1);
                    if (idx_q == 3'd7 || in_last) begin
                        state_d = LAUNCH;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            LAUNCH: begin
                // Lanes stay on the tree inputs until a credit is available.
                if (credit_ok) begin
                    launch  = 1'b1;
                    lanes_d = '0;
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // In-flight tracking and result FIFO
    always_comb begin
        v_d      = {v_q[TREE_LAT-2:0], launch};
        cp_d     = {cp_q[TREE_LAT-2:0], fcnt_q};
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{sum: tree_y, cnt: cp_q[TREE_LAT-1]};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLLECT;
            idx_q    <= '0;
            fcnt_q   <= '0;
            lanes_q  <= '0;
            v_q      <= '0;
            cp_q     <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fcnt_q   <= fcnt_d;
            lanes_q  <= lanes_d;
            v_q      <= v_d;
            cp_q     <= cp_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule
